// File: rtl/cache_fill_fsm_pkg.sv
// cache_pkg: shared line geometry and fill-state encoding for the cache
// fill controllers, the memory arbiter and bench monitors.
//   ADDR_W / DATA_W    : byte address and memory word widths
//   WORDS_PER_LINE     : memory words per cache line
//   LINE_OFFSET_BITS   : byte offset bits within a line
//   WORD_SEL_BITS      : word index bits within a line
//   fill_state_t       : IDLE=0, FILL=1
//   wordAddr()         : byte address of word <sel> inside the line at <base>
package cache_pkg;

  localparam int ADDR_W           = 16;
  localparam int DATA_W           = 16;
  localparam int WORDS_PER_LINE   = 8;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int WORD_SEL_BITS    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Offset is spliced into the low bits, so a line at the top of memory
  // never carries into the next line or wraps to zero.
  function automatic logic [ADDR_W-1:0] wordAddr(
    input logic [ADDR_W-1:0]        base,
    input logic [WORD_SEL_BITS-1:0] sel
  );
    return {base[ADDR_W-1:LINE_OFFSET_BITS], sel, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: bundle of the miss, memory and array-write signals of
// one fill controller.
//   master : the fill controller (drives stall, memory requests, array writes)
//   slave  : the cache/memory side (drives miss info and returned data)
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] fill_address;
  logic [DATA_W-1:0] fill_data;

  modport master (
    input  miss_detected, miss_address, mem_data_valid, mem_data,
    output fsm_busy, mem_read_en, mem_address,
           write_data_array, write_tag_array, fill_address, fill_data
  );

  modport slave (
    output miss_detected, miss_address, mem_data_valid, mem_data,
    input  fsm_busy, mem_read_en, mem_address,
           write_data_array, write_tag_array, fill_address, fill_data
  );

endinterface

// File: rtl/cache_fill_fsm_counter.sv
// fill_word_counter: word index within a line, saturating at the last word.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous clear back to word 0
//   en         : advance by one word
//   count      : current word index (holds at the last word)
//   done       : set once the last word has been counted
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  output logic [WORD_SEL_BITS-1:0] count,
  output logic                     done
);

  localparam logic [WORD_SEL_BITS-1:0] LAST_WORD = WORD_SEL_BITS'(WORDS_PER_LINE - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (en && !done) begin
      // done stands in for the ninth count value, keeping count 3 bits wide
      if (count == LAST_WORD) begin
        done <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, stalls the pipeline, requests the whole
// line from pipelined main memory one word per cycle, writes each returned
// word into the data array and writes the tag with the last word.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cache_fill_fsm_if.master (miss in, memory request/return,
//                data/tag array writes, stall)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no fill in progress; a miss stalls at once and starts a fill
// FILL  | issuing line requests and absorbing returned words until 8th
module cache_fill_fsm
  import cache_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  cache_fill_fsm_if.master bus
);

  fill_state_t               stateQ, stateD;
  logic [ADDR_W-1:0]         lineBaseQ;
  logic [WORD_SEL_BITS-1:0]  issueCnt, recvCnt;
  logic                      issueDone, recvDone;
  logic                      inFill, recvEn, lastWord;

  localparam logic [WORD_SEL_BITS-1:0] LAST_WORD = WORD_SEL_BITS'(WORDS_PER_LINE - 1);

  assign inFill   = (stateQ == FILL);
  assign recvEn   = inFill && bus.mem_data_valid;
  assign lastWord = recvEn && (recvCnt == LAST_WORD) && !recvDone;

  // Counters are held clear throughout IDLE, so every fill starts at word 0
  // and an aborted fill leaves nothing behind.
  fill_word_counter uIssueCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!inFill),
    .en    (inFill),
    .count (issueCnt),
    .done  (issueDone)
  );

  fill_word_counter uRecvCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!inFill),
    .en    (recvEn),
    .count (recvCnt),
    .done  (recvDone)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lineBaseQ <= '0;
    end else if (!inFill && bus.miss_detected) begin
      lineBaseQ <= {bus.miss_address[ADDR_W-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
    end
  end

  always_comb begin
    stateD               = stateQ;
    bus.fsm_busy         = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.mem_address      = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_address     = '0;
    bus.fill_data        = '0;

    case (stateQ)
      IDLE: begin
        // Stall is raised in the miss cycle itself; held off while in reset
        // so the pipeline sees a clean idle controller.
        bus.fsm_busy = bus.miss_detected && rst_n;
        if (bus.miss_detected) begin
          stateD = FILL;
        end
      end

      FILL: begin
        bus.fsm_busy = 1'b1;
        if (!issueDone) begin
          bus.mem_read_en = 1'b1;
          bus.mem_address = wordAddr(lineBaseQ, issueCnt);
        end
        if (recvEn && !recvDone) begin
          bus.write_data_array = 1'b1;
          bus.fill_address     = wordAddr(lineBaseQ, recvCnt);
          bus.fill_data        = bus.mem_data;
        end
        if (lastWord) begin
          bus.write_tag_array = 1'b1;
          stateD              = IDLE;
        end
      end

      default: stateD = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for cache_fill_fsm with a pipelined
// memory model that returns data equal to the requested address.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passCnt = 0;
  int checkCnt = 0;

  int cyc = 0;
  int lat = 4;
  int bubAfter = 99;
  int bubLen = 0;
  int reqTotal = 0;
  int dueCyc[$];
  logic [15:0] dueAddr[$];

  logic oBusy, oRd, oWr, oTag;
  logic [15:0] oAddr, oFaddr, oFdata;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Entered just after a posedge with miss inputs already set; drives memory
  // return for this cycle, samples outputs at negedge, leaves at next posedge+1.
  task automatic runCycle(input bit forceValid);
    if (dueCyc.size() > 0 && dueCyc[0] == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = dueAddr[0];
      void'(dueCyc.pop_front());
      void'(dueAddr.pop_front());
    end else if (forceValid) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 16'hBEEF;
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = 16'h0000;
    end
    @(negedge clk);
    oBusy  = bus.fsm_busy;
    oRd    = bus.mem_read_en;
    oAddr  = bus.mem_address;
    oWr    = bus.write_data_array;
    oTag   = bus.write_tag_array;
    oFaddr = bus.fill_address;
    oFdata = bus.fill_data;
    if (oRd) begin
      dueCyc.push_back(cyc + lat + ((reqTotal > bubAfter) ? bubLen : 0));
      dueAddr.push_back(oAddr);
      reqTotal++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runFill(input logic [15:0] missAddr, input logic [15:0] expBase,
                         input int latency, input int bAfter, input int bLen,
                         input bit holdMiss, input logic [15:0] holdAddr,
                         output int firstReq, output int lastReq, output int firstWr,
                         output int tagCyc, output logic [15:0] lastAddr);
    int nReq, nWr, nTag;
    bit reqOk, wrOk, tagOk, busyOk;
    lat = latency; bubAfter = bAfter; bubLen = bLen; reqTotal = 0;
    dueCyc.delete(); dueAddr.delete();
    nReq = 0; nWr = 0; nTag = 0;
    reqOk = 1; wrOk = 1; tagOk = 1; busyOk = 1;
    firstReq = -1; lastReq = -1; firstWr = -1; tagCyc = -1; lastAddr = '0;
    bus.miss_detected = 1'b1;
    bus.miss_address  = missAddr;
    for (int k = 0; k < 64 && tagCyc < 0; k++) begin
      runCycle(1'b0);
      if (k == 0) begin
        bus.miss_detected = holdMiss;
        bus.miss_address  = holdAddr;
      end
      if (!oBusy) busyOk = 0;
      if (oRd) begin
        if (oAddr !== 16'(expBase + 2 * nReq)) reqOk = 0;
        if (nReq == 0) firstReq = k;
        lastReq  = k;
        lastAddr = oAddr;
        nReq++;
      end
      if (oWr) begin
        if (oFaddr !== 16'(expBase + 2 * nWr) || oFdata !== oFaddr) wrOk = 0;
        if (nWr == 0) firstWr = k;
        nWr++;
      end
      if (oTag) begin
        nTag++;
        tagCyc = k;
        if (!oWr || nWr != 8 || oFaddr[15:4] !== expBase[15:4]) tagOk = 0;
      end
    end
    checkVal("reqCount", nReq, 8);
    checkVal("reqOrder", reqOk, 1);
    checkVal("wrCount", nWr, 8);
    checkVal("wrOrder", wrOk, 1);
    checkVal("tagCount", nTag, 1);
    checkVal("tagWithLast", tagOk, 1);
    checkVal("busyHeld", busyOk, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fr, lr, fw, tc, nWr, nTag;
    logic [15:0] la, firstNewAddr;
    bit done;

    // 1. reset with miss asserted
    rst_n = 1'b0;
    bus.miss_detected  = 1'b1;
    bus.miss_address   = 16'h1236;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("rstOuts", {bus.fsm_busy, bus.mem_read_en, bus.mem_address, bus.write_data_array,
                         bus.write_tag_array, bus.fill_address, bus.fill_data}, 64'd0);
    checkVal("rstState", dut.stateQ, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.miss_detected = 1'b0;
    @(negedge clk);
    checkVal("rstRelBusy", bus.fsm_busy, 1'b0);
    @(posedge clk); #1;

    // 2. miss at 0x1236, 4-cycle memory
    runFill(16'h1236, 16'h1230, 4, 99, 0, 1'b0, 16'h0000, fr, lr, fw, tc, la);
    checkVal("t2FirstReq", fr, 1);
    checkVal("t2LastReq", lr, 8);
    checkVal("t2FirstWr", fw, 5);
    checkVal("t2TagCyc", tc, 12);
    runCycle(1'b0);
    checkVal("t2BusyDrop", oBusy, 1'b0);

    // 3. miss held high, address moves to 0x0040 during fill
    runFill(16'h1236, 16'h1230, 4, 99, 0, 1'b1, 16'h0040, fr, lr, fw, tc, la);
    checkVal("t3TagCyc", tc, 12);
    runCycle(1'b0);
    checkVal("t3BusyCont", oBusy, 1'b1);
    bus.miss_detected = 1'b0;
    runCycle(1'b0);
    checkVal("t3NewReq", {oRd, oAddr}, {1'b1, 16'h0040});
    nWr = 0; done = 0; firstNewAddr = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      runCycle(1'b0);
      if (oWr) begin
        if (nWr == 0) firstNewAddr = oFaddr;
        nWr++;
      end
      if (!oBusy) done = 1;
    end
    checkVal("t3NewDone", done, 1'b1);
    checkVal("t3NewWrites", nWr, 8);
    checkVal("t3NewFirstWr", firstNewAddr, 16'h0040);

    // 4. 6-cycle latency, 2-cycle bubble after word 3
    runFill(16'h3456, 16'h3450, 6, 3, 2, 1'b0, 16'h0000, fr, lr, fw, tc, la);
    checkVal("t4FirstWr", fw, 7);
    checkVal("t4TagCyc", tc, 16);
    runCycle(1'b0);
    checkVal("t4BusyDrop", oBusy, 1'b0);

    // 5. top-of-memory line
    runFill(16'hFFFE, 16'hFFF0, 4, 99, 0, 1'b0, 16'h0000, fr, lr, fw, tc, la);
    checkVal("t5LastReqAddr", la, 16'hFFFE);
    runCycle(1'b0);
    checkVal("t5BusyDrop", oBusy, 1'b0);

    // 6. reset mid-fill after 3 words, then stray valids
    lat = 4; bubAfter = 99; bubLen = 0; reqTotal = 0;
    dueCyc.delete(); dueAddr.delete();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h2002;
    nWr = 0;
    for (int k = 0; k < 30 && nWr < 3; k++) begin
      runCycle(1'b0);
      bus.miss_detected = 1'b0;
      if (oWr) nWr++;
    end
    checkVal("t6Words", nWr, 3);
    rst_n = 1'b0;
    runCycle(1'b0);
    rst_n = 1'b1;
    runCycle(1'b0);
    checkVal("t6RstOuts", {oBusy, oRd, oAddr, oWr, oTag, oFaddr, oFdata}, 64'd0);
    nWr = 0; nTag = 0;
    for (int k = 0; k < 8; k++) begin
      runCycle(1'b0);
      if (oWr) nWr++;
      if (oTag) nTag++;
    end
    checkVal("t6StrayWr", nWr, 0);
    checkVal("t6StrayTag", nTag, 0);
    dueCyc.delete(); dueAddr.delete();
    runCycle(1'b1);
    checkVal("t6IdleValid", {oBusy, oWr, oTag}, 3'b000);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
